uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter for the control system, mirroring the receive path. It takes one parallel byte per handshake and serialises it onto `TX_OUT` as a frame: start bit, 8 data bits LSB first, an optional parity bit, and a stop bit. Each bit is held for `Prescale` clock cycles. The block sits between the system controller / register-file read path and the serial pin, and returns read data and responses to the host.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: payload bits per frame.
- `PRESCALE_WIDTH`, default 4: width of `Prescale`.

Ports (one clock; reset is synchronous and active-low):
- `CLK` input 1: single clock; all state changes on the rising edge.
- `RST` input 1: synchronous, active-low reset.
- `P_DATA` input `DATA_WIDTH`: byte to send; sampled only on acceptance.
- `Data_Valid` input 1: send request; accepted only when `busy`=0.
- `PAR_EN` input 1: 1 = parity bit present.
- `PAR_TYP` input 1: 0 = even, 1 = odd; sampled on acceptance.
- `Prescale` input `PRESCALE_WIDTH`: clock cycles per bit; 0 is treated as 1; sampled on acceptance.
- `TX_OUT` output 1: serial line, registered, idle high.
- `busy` output 1: registered; high from the first start-bit cycle to the last stop-bit cycle.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance:
  - In IDLE with `Data_Valid`=1, register `P_DATA`, `PAR_EN`, `PAR_TYP` and `Prescale` into a frame-config register and go to START.
  - Input changes after acceptance do not affect the frame in flight.
- Per-bit counter `tick_cnt` counts 0 .. `Prescale`-1. The state advances when `tick_cnt` = `Prescale`-1.
- START: `TX_OUT`=0. Then go to DATA with bit index 0.
- DATA: `TX_OUT` = `data_reg[bit_idx]`, LSB first. After bit `DATA_WIDTH`-1, go to PARITY if parity is enabled, else STOP.
- PARITY: `TX_OUT` = XOR of the latched data bits, inverted when `PAR_TYP`=1. Then go to STOP.
- STOP: `TX_OUT`=1. Then go to IDLE.
- `Data_Valid` while `busy`=1 is ignored: no queueing and no error.
- `busy` is 0 in IDLE and 1 in every other state.

## Timing
- Reset: `RST`=0 at a rising edge, from any state, gives on the next cycle `TX_OUT`=1, `busy`=0, state IDLE, and clears all counters.
  - A frame in flight is truncated; the line returns high immediately.
- Latency: `Data_Valid` is sampled high in IDLE at edge N. `TX_OUT`=0 and `busy`=1 are visible after edge N (registered start bit).
- Frame length: (10 + `PAR_EN`) × max(`Prescale`,1) cycles.
- `busy` falls at the edge ending the last stop-bit cycle.
- Minimum inter-frame gap: 1 cycle of IDLE. A request during the final stop cycle is ignored, because `busy` is still 1.
- Back-to-back: holding `Data_Valid` high continuously sends a new frame every frame-length + 1 cycles.
- Simultaneous `RST`=0 and `Data_Valid`=1: reset wins and nothing is accepted.

## Structure
- Shared package `uart_pkg`:
  - State enum `uart_tx_state_t`.
  - Parity-type constants `PAR_EVEN`=0, `PAR_ODD`=1.
  - Default `DATA_WIDTH` and `PRESCALE_WIDTH`.
  - The RX side uses the same package.
- Natural sub-module: `parity_calc`. It is combinational XOR-reduce plus type select, and is reusable by the RX parity checker.
- The FSM, bit counter, tick counter and output register stay in `uart_tx`.

## Test plan
Clock period is 5 ns and `Prescale`=8 unless stated.
1. Reset: hold `RST`=0 for 2 edges with `Data_Valid`=1 -> `TX_OUT`=1, `busy`=0, no frame starts.
2. Odd parity frame: `P_DATA`=8'b10010011, `PAR_EN`=1, `PAR_TYP`=1 -> `TX_OUT` = 0, 1,1,0,0,1,0,0,1, 1 (parity), 1 (stop), each held 8 cycles. `busy` is high for exactly 88 cycles.
3. Even parity frame: `P_DATA`=8'h0F, `PAR_EN`=1, `PAR_TYP`=0 -> bits 1,1,1,1,0,0,0,0, parity 0, stop 1; 88 cycles.
4. No parity, minimum prescale: `PAR_EN`=0, `Prescale`=0, `P_DATA`=8'hA5 -> 10-cycle frame 0,1,0,1,0,0,1,0,1,1; `busy` high for 10 cycles.
5. Isolation while busy: pulse `Data_Valid` and change `P_DATA`/`PAR_TYP` mid-frame -> the frame in flight is unchanged and the second request is dropped. Holding `Data_Valid` high instead -> the next start bit appears exactly 1 idle cycle after the stop bit.
6. Reset mid-frame: assert `RST`=0 during data bit 3 -> `TX_OUT`=1 and `busy`=0 the next cycle. After reset releases, a new request produces a full, correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-type codes and default widths.
// Both the TX and RX paths import this package.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_PRESCALE_WIDTH = 4;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel request side and serial/status side of the UART transmitter.
`timescale 1ns/1ps
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) ();

    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      TX_OUT;
    logic                      busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, busy
    );

endinterface

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator: XOR-reduce of the payload, inverted for odd parity.
`timescale 1ns/1ps
module parity_calc
    import uart_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             par_typ_i,
    output logic             par_o
);

    assign par_o = (^data_i) ^ (par_typ_i == PAR_ODD);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, optional parity, stop bit,
// each held for max(Prescale,1) clocks. Outputs are registered.
`timescale 1ns/1ps
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
    input  logic     CLK,
    input  logic     RST,
    uart_tx_if.slave tx_if
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    uart_tx_state_t            state_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      par_en_q;
    logic                      par_typ_q;
    logic [PRESCALE_WIDTH-1:0] last_tick_q;
    logic [PRESCALE_WIDTH-1:0] tick_q, tick_d;
    logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
    logic                      tx_q;
    logic                      busy_q;
    logic                      tick_done;
    logic                      par_bit;

    parity_calc #(.WIDTH(DATA_WIDTH)) u_parity (
        .data_i    (data_q),
        .par_typ_i (par_typ_q),
        .par_o     (par_bit)
    );

    assign tick_done = (tick_q == last_tick_q);
    assign tick_d    = tick_done ? '0 : tick_q + PRESCALE_WIDTH'(1);
    assign bit_idx_d = bit_idx_q + IDX_W'(1);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            data_q      <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= PAR_EVEN;
            last_tick_q <= '0;
            tick_q      <= '0;
            bit_idx_q   <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            if (state_q != IDLE) tick_q <= tick_d;
            case (state_q)
                IDLE: begin
                    if (tx_if.Data_Valid) begin
                        data_q      <= tx_if.P_DATA;
                        par_en_q    <= tx_if.PAR_EN;
                        par_typ_q   <= tx_if.PAR_TYP;
                        // Store the last tick index; a prescale of 0 behaves like 1.
                        last_tick_q <= (tx_if.Prescale == '0) ? '0
                                       : tx_if.Prescale - PRESCALE_WIDTH'(1);
                        tick_q      <= '0;
                        state_q     <= START;
                        tx_q        <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                START: begin
                    if (tick_done) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                        tx_q      <= data_q[0];
                    end
                end
                DATA: begin
                    if (tick_done) begin
                        if (bit_idx_q == LAST_IDX) begin
                            state_q <= par_en_q ? PARITY : STOP;
                            tx_q    <= par_en_q ? par_bit : 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_d;
                            tx_q      <= data_q[bit_idx_d];
                        end
                    end
                end
                PARITY: begin
                    if (tick_done) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
                STOP: begin
                    if (tick_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_if.TX_OUT = tx_q;
    assign tx_if.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted requests are predicted from frame-length
// arithmetic, and a negedge monitor checks every line/busy cycle against them.
`timescale 1ns/1ps
module tb_uart_tx;

    logic clk = 1'b0;
    logic rst;
    always #2.5 clk = ~clk;

    uart_tx_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(4)) bus ();

    uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(4)) dut (
        .CLK   (clk),
        .RST   (rst),
        .tx_if (bus.slave)
    );

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic [3:0] ps;
        int         start;
    } frame_t;

    frame_t q[$];
    int     cyc        = 0;
    int     next_ok    = 0;
    logic   rst_edge   = 1'b0;
    int     vectors    = 0;
    int     miscompares = 0;
    logic   active     = 1'b0;

    function automatic int eff_ps(frame_t f);
        return (f.ps == 0) ? 1 : int'(f.ps);
    endfunction

    function automatic int flen(frame_t f);
        return (10 + int'(f.pe)) * eff_ps(f);
    endfunction

    // Expected line level k cycles into a frame, from the frame layout.
    function automatic logic exp_bit(frame_t f, int k);
        int b;
        b = k / eff_ps(f);
        if (b == 0) return 1'b0;
        if (b <= 8) return f.data[b-1];
        if (b == 9 && f.pe) return (^f.data) ^ f.pt;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: decide acceptance from when the line is free again.
    always @(posedge clk) begin
        frame_t f;
        rst_edge = !rst;
        if (!rst) begin
            next_ok = cyc + 1;
        end else if (bus.Data_Valid === 1'b1 && cyc >= next_ok) begin
            f.data  = bus.P_DATA;
            f.pe    = bus.PAR_EN;
            f.pt    = bus.PAR_TYP;
            f.ps    = bus.Prescale;
            f.start = cyc;
            q.push_back(f);
            next_ok = cyc + flen(f) + 1;
        end
        cyc++;
    end

    // Monitor
    frame_t cur;
    int     k = 0;
    always @(negedge clk) begin
        if (rst_edge) begin
            active = 1'b0;
            chk("rst_tx", {31'd0, bus.TX_OUT}, 32'd1);
            chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        end else if (active) begin
            chk("tx_bit", {31'd0, bus.TX_OUT}, {31'd0, exp_bit(cur, k)});
            chk("busy_hi", {31'd0, bus.busy}, 32'd1);
            k++;
            if (k >= flen(cur)) active = 1'b0;
        end else if (bus.busy === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_frame", {31'd0, bus.busy}, 32'd0);
            end else begin
                cur = q.pop_front();
                chk("start_cycle", cyc, cur.start + 1);
                chk("start_bit", {31'd0, bus.TX_OUT}, 32'd0);
                k = 1;
                active = (k < flen(cur));
            end
        end else begin
            chk("idle_tx", {31'd0, bus.TX_OUT}, 32'd1);
            chk("idle_busy", {31'd0, bus.busy}, 32'd0);
            chk("missed_start", q.size(), 0);
        end
    end

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [3:0] ps);
        int p;
        @(negedge clk);
        bus.P_DATA = d; bus.PAR_EN = pe; bus.PAR_TYP = pt; bus.Prescale = ps;
        bus.Data_Valid = 1'b1;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        p = (ps == 0) ? 1 : int'(ps);
        repeat ((10 + int'(pe)) * p + 2) @(negedge clk);
    endtask

    initial begin
        // Reset held with a pending request: nothing may start.
        rst = 1'b0;
        bus.Data_Valid = 1'b1; bus.P_DATA = 8'h3C; bus.PAR_EN = 1'b1;
        bus.PAR_TYP = 1'b0; bus.Prescale = 4'd8;
        repeat (2) @(negedge clk);
        bus.Data_Valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        send(8'b10010011, 1'b1, 1'b1, 4'd8);
        send(8'h0F, 1'b1, 1'b0, 4'd8);
        send(8'hA5, 1'b0, 1'b0, 4'd0);

        // Requests and input changes while busy must not disturb the frame.
        @(negedge clk);
        bus.P_DATA = 8'h5A; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.Prescale = 4'd8;
        bus.Data_Valid = 1'b1;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        repeat (20) @(negedge clk);
        bus.P_DATA = 8'hFF; bus.PAR_TYP = 1'b1; bus.Prescale = 4'd2;
        bus.Data_Valid = 1'b1;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        repeat (40) @(negedge clk);
        bus.Data_Valid = 1'b1;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        repeat (40) @(negedge clk);

        // Held request: back-to-back frames with one idle cycle between.
        bus.Data_Valid = 1'b1;
        for (int i = 0; i < 120; i++) begin
            bus.P_DATA   = 8'($urandom);
            bus.PAR_TYP  = 1'($urandom);
            bus.PAR_EN   = 1'($urandom);
            bus.Prescale = 4'($urandom_range(0, 3));
            @(negedge clk);
        end
        bus.Data_Valid = 1'b0;
        repeat (50) @(negedge clk);

        // Reset during data bit 3 (cycles 32..39 of an 8x frame).
        @(negedge clk);
        bus.P_DATA = 8'hC3; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b1; bus.Prescale = 4'd8;
        bus.Data_Valid = 1'b1;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        repeat (34) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        send(8'h96, 1'b1, 1'b0, 4'd8);

        // Random frames with random gaps.
        for (int i = 0; i < 40; i++) begin
            int hold, gap;
            hold = $urandom_range(1, 3);
            gap  = $urandom_range(0, 20);
            @(negedge clk);
            bus.P_DATA   = 8'($urandom);
            bus.PAR_EN   = 1'($urandom);
            bus.PAR_TYP  = 1'($urandom);
            bus.Prescale = 4'($urandom_range(0, 4));
            bus.Data_Valid = 1'b1;
            repeat (hold) @(negedge clk);
            bus.Data_Valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        repeat (80) @(negedge clk);

        chk("queue_drained", q.size(), 0);
        chk("monitor_idle", {31'd0, active}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
